// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element tables for the RAM BIST controller.
// Table bit i describes march element Mi.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CHK,
        S_NEXT,
        S_DONE
    } state_e;

    localparam int              NUM_ELEM  = 6;
    localparam logic [2:0]      LAST_ELEM = 3'(NUM_ELEM - 1);

    // M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 | M5 up r0
    localparam logic [NUM_ELEM-1:0] EL_UP   = 6'b100111;
    localparam logic [NUM_ELEM-1:0] EL_RD   = 6'b111110;
    localparam logic [NUM_ELEM-1:0] EL_WR   = 6'b011111;
    localparam logic [NUM_ELEM-1:0] EL_REXP = 6'b010100;
    localparam logic [NUM_ELEM-1:0] EL_WBIT = 6'b001010;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down march address counter; is_last_o flags the terminal address of the
// current direction so the controller never depends on wrap or underflow.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              load_up_i,
    input  logic              step_i,
    input  logic              up_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              is_last_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else if (load_i)
            addr_q <= load_up_i ? '0 : ADDR_MAX;
        else if (step_i)
            addr_q <= up_i ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end

    assign addr_o    = addr_q;
    assign is_last_o = up_i ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST initiator for a single-port synchronous RAM.
// Define RAM_BIST_DIAG_EN to capture the first failure and stop the test there.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e             state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;
    logic               pass_q, pass_d;
    logic               ready_q;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               ag_load, ag_load_up, ag_step, ag_last;
    logic               start_ok, miscmp;

    // ready_q blocks a start sampled on the first edge after reset release
    assign start_ok = start && ready_q && (state_q == S_IDLE || state_q == S_DONE);
    assign miscmp   = (state_q == S_CHK) && (ram_dataout != {DATA_W{EL_REXP[elem_q]}});

    ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ag_load),
        .load_up_i (ag_load_up),
        .step_i    (ag_step),
        .up_i      (EL_UP[elem_q]),
        .addr_o    (ram_addr),
        .is_last_o (ag_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            wait_q  <= '0;
            pass_q  <= 1'b0;
            ready_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
            ready_q <= 1'b1;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        wait_d     = '0;
        ag_load    = 1'b0;
        ag_load_up = 1'b1;
        ag_step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_WR;
                    elem_d  = '0;
                    ag_load = 1'b1;
                end
            end
            S_WR:   state_d = S_NEXT;
            S_RD:   state_d = (RD_LAT > 1) ? S_WAIT : S_CHK;
            S_WAIT: begin
                wait_d = wait_q + WCNT_W'(1);
                if (int'(wait_q) >= RD_LAT - 2)
                    state_d = S_CHK;
            end
            S_CHK: begin
`ifdef RAM_BIST_DIAG_EN
                if (miscmp)
                    state_d = S_DONE;
                else
`endif
                    state_d = EL_WR[elem_q] ? S_WR : S_NEXT;
            end
            S_NEXT: begin
                if (!ag_last) begin
                    ag_step = 1'b1;
                    state_d = EL_RD[elem_q] ? S_RD : S_WR;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = S_DONE;
                end else begin
                    elem_d     = 3'(elem_q + 3'd1);
                    ag_load    = 1'b1;
                    ag_load_up = EL_UP[elem_d];
                    state_d    = EL_RD[elem_d] ? S_RD : S_WR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM strobes are registered from the next state so they line up with RD/WR
    always_comb begin
        busy   = !(state_q == S_IDLE || state_q == S_DONE);
        done   = (state_q == S_DONE);
        rd_d   = (state_d == S_RD);
        wr_d   = (state_d == S_WR);
        din_d  = wr_d ? {DATA_W{EL_WBIT[elem_d]}} : din_q;
        pass_d = pass_q;
        if (start_ok)
            pass_d = 1'b1;
        else if (miscmp)
            pass_d = 1'b0;
    end

    assign pass       = pass_q;
    assign ram_read   = rd_q;
    assign ram_write  = wr_q;
    assign ram_datain = din_q;

`ifdef RAM_BIST_DIAG_EN
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;
    logic [DATA_W-1:0] fail_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else if (start_ok) begin
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else if (miscmp && pass_q) begin
            fail_addr_q <= ram_addr;
            fail_elem_q <= elem_q;
            fail_data_q <= ram_dataout;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_elem = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: behavioural RAM (RD_LAT=1, N=16) with stuck-at hooks.
module tb_ram_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, ram_read, ram_write;
    logic [AW-1:0] fail_addr, ram_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data, ram_datain;
    logic [DW-1:0] ram_dataout = '0;

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_addr   (fail_addr),
        .fail_elem   (fail_elem),
        .fail_data   (fail_data),
        .ram_addr    (ram_addr),
        .ram_datain  (ram_datain),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_dataout (ram_dataout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    int            sa1_addr = -1, sa0_addr = -1;
    logic [DW-1:0] sa1_mask = '0, sa0_mask = '0;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = v;
        if (int'(a) == sa1_addr) r = r | sa1_mask;
        if (int'(a) == sa0_addr) r = r & ~sa0_mask;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_datain;
        if (ram_read)  ram_dataout <= faulty(mem[ram_addr], ram_addr);
    end

    int            busy_cnt, both_cnt, rd_cnt, wr_cnt, post_cnt;
    logic [AW-1:0] rd_trace [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (ram_read && ram_write) both_cnt++;
            if (ram_read) begin
                rd_cnt++;
                rd_trace.push_back(ram_addr);
            end
            if (ram_write) wr_cnt++;
            if (done && (ram_read || ram_write)) post_cnt++;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic run_test(input bit extra_starts);
        busy_cnt = 0; both_cnt = 0; rd_cnt = 0; wr_cnt = 0; post_cnt = 0;
        rd_trace.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1 start = extra_starts && (cyc == 5 || cyc == 100);
        end
        start = 1'b0;
        chk("done", done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int bad;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", {busy, done, pass, fail_addr, fail_elem, fail_data,
                              ram_addr, ram_datain, ram_read, ram_write}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // fault-free run
        run_test(1'b0);
        chk("clean_busy", busy_cnt, 336);
        chk("clean_pass", pass, 1);
        chk("clean_rw_overlap", both_cnt, 0);
        chk("clean_reads", rd_cnt, 80);
        chk("clean_writes", wr_cnt, 80);
        chk("clean_fail_info", {fail_addr, fail_elem, fail_data}, 0);
        bad = 0;
        if (rd_trace.size() < 48) bad = 16;
        else for (int i = 0; i < 16; i++) if (int'(rd_trace[32 + i]) != 15 - i) bad++;
        chk("m3_order", bad, 0);

        // bit0 of address 5 stuck at 1: caught by M1 r0
        sa1_addr = 5; sa1_mask = 4'h1;
        run_test(1'b0);
        chk("sa1_pass", pass, 0);
        chk("sa1_post_access", post_cnt, 0);
`ifdef RAM_BIST_DIAG_EN
        chk("sa1_busy", busy_cnt, 54);
        chk("sa1_fail_addr", fail_addr, 5);
        chk("sa1_fail_elem", fail_elem, 1);
        chk("sa1_fail_data", fail_data, 1);
`else
        chk("sa1_busy", busy_cnt, 336);
        chk("sa1_fail_info", {fail_addr, fail_elem, fail_data}, 0);
`endif
        sa1_addr = -1; sa1_mask = '0;

        // bit3 of address 0xA stuck at 0: caught by M2 r1
        sa0_addr = 10; sa0_mask = 4'h8;
        run_test(1'b0);
        chk("sa0_pass", pass, 0);
`ifdef RAM_BIST_DIAG_EN
        chk("sa0_busy", busy_cnt, 138);
        chk("sa0_fail_addr", fail_addr, 4'hA);
        chk("sa0_fail_elem", fail_elem, 2);
        chk("sa0_fail_data", fail_data, 4'h7);
`else
        chk("sa0_busy", busy_cnt, 336);
`endif
        sa0_addr = -1; sa0_mask = '0;

        // restart after a failure, with start pulses while busy
        run_test(1'b1);
        chk("restart_busy", busy_cnt, 336);
        chk("restart_pass", pass, 1);

        // reset mid-test, then a start coinciding with reset release
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (48) @(posedge clk);
        #1 chk("busy_before_rst", busy, 1);
        #1 rst_n = 1'b0;
        #1 chk("midrst_outs", {busy, done, pass, fail_addr, fail_elem, fail_data,
                               ram_addr, ram_datain, ram_read, ram_write}, 0);
        @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_at_release_ignored", busy, 0);
        run_test(1'b0);
        chk("post_rst_busy", busy_cnt, 336);
        chk("post_rst_pass", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
